// File: rtl/bandit_pkg.sv
// Shared types and helpers for the epsilon-greedy bandit agent.
// value_update is also used by reference models outside the RTL.
package bandit_pkg;

    typedef enum logic [2:0] {
        INIT,
        SELECT,
        ACTION,
        REWARD,
        UPDATE
    } state_t;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Move q toward r by (r - q) / 2^shift, rounded toward minus infinity.
    // The result always lies between q and r, so it fits the table width.
    function automatic int value_update(input int q, input int r, input int unsigned shift);
        int diff;
        diff = r - q;
        return q + (diff >>> shift);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that free-runs out of reset; drives exploration decisions.
module lfsr16
    import bandit_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] state
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= SEED;
        end else if (state[0]) begin
            state <= (state >> 1) ^ LFSR_TAPS;
        end else begin
            state <= state >> 1;
        end
    end

endmodule

// File: rtl/epsilon_bandit.sv
// Epsilon-greedy bandit agent: offers one action per round, learns from the
// returned reward with a shift-based learning rate.
module epsilon_bandit
    import bandit_pkg::*;
#(
    parameter int unsigned ACTIONS      = 256,
    parameter int unsigned ACTION_WIDTH = $clog2(ACTIONS),
    parameter int unsigned VALUE_WIDTH  = 8,
    parameter int unsigned REWARD_WIDTH = 8,
    parameter int          INIT_VALUE   = 5,
    parameter int unsigned RATE_SHIFT   = 2,
    parameter int unsigned EPSILON      = 26,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    action_valid,
    output logic [ACTION_WIDTH-1:0] action_data,
    input  logic                    action_ready,
    input  logic                    reward_valid,
    input  logic [REWARD_WIDTH-1:0] reward_data,
    output logic                    reward_ready,
    output logic                    explored
);

    localparam logic [ACTION_WIDTH-1:0] LAST_INDEX = ACTION_WIDTH'(ACTIONS - 1);

    state_t                         state;
    logic [ACTION_WIDTH-1:0]        index;
    logic [ACTION_WIDTH-1:0]        best_idx;
    logic [ACTION_WIDTH-1:0]        rand_idx;
    logic [ACTION_WIDTH-1:0]        chosen;
    logic signed [VALUE_WIDTH-1:0]  best_val;
    logic signed [VALUE_WIDTH-1:0]  scan_val;
    logic signed [VALUE_WIDTH-1:0]  updated;
    logic signed [REWARD_WIDTH-1:0] reward_latched;
    logic                           explore;
    logic                           last_index;
    logic                           scan_better;
    logic [15:0]                    lfsr_state;

    logic signed [VALUE_WIDTH-1:0]  action_value_table [ACTIONS];

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .state (lfsr_state)
    );

    always_comb begin
        scan_val    = action_value_table[index];
        last_index  = (index == LAST_INDEX);
        // strictly-greater replacement keeps ties on the lowest index
        scan_better = (index == '0) || (scan_val > best_val);
        updated     = VALUE_WIDTH'(value_update(int'(action_value_table[chosen]),
                                                int'(reward_latched), RATE_SHIFT));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= INIT;
            index          <= '0;
            best_idx       <= '0;
            best_val       <= '0;
            rand_idx       <= '0;
            explore        <= 1'b0;
            chosen         <= '0;
            reward_latched <= '0;
            action_valid   <= 1'b0;
            action_data    <= '0;
            explored       <= 1'b0;
            reward_ready   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    index <= last_index ? '0 : index + 1'b1;
                    if (last_index) begin
                        state    <= SELECT;
                        explore  <= {1'b0, lfsr_state[15:8]} < 9'(EPSILON);
                        rand_idx <= lfsr_state[ACTION_WIDTH-1:0];
                    end
                end
                SELECT: begin
                    if (scan_better) begin
                        best_val <= scan_val;
                        best_idx <= index;
                    end
                    index <= last_index ? '0 : index + 1'b1;
                    // the scan always runs to the end so latency is fixed
                    if (last_index) begin
                        action_data  <= explore ? rand_idx : (scan_better ? index : best_idx);
                        explored     <= explore;
                        action_valid <= 1'b1;
                        state        <= ACTION;
                    end
                end
                ACTION: begin
                    if (action_ready) begin
                        action_valid <= 1'b0;
                        reward_ready <= 1'b1;
                        chosen       <= action_data;
                        state        <= REWARD;
                    end
                end
                REWARD: begin
                    if (reward_valid) begin
                        reward_ready   <= 1'b0;
                        reward_latched <= reward_data;
                        state          <= UPDATE;
                    end
                end
                UPDATE: begin
                    state    <= SELECT;
                    index    <= '0;
                    explore  <= {1'b0, lfsr_state[15:8]} < 9'(EPSILON);
                    rand_idx <= lfsr_state[ACTION_WIDTH-1:0];
                end
                default: state <= INIT;
            endcase
        end
    end

    // No reset on the table itself: INIT rewrites every entry after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state == INIT) begin
                action_value_table[index] <= VALUE_WIDTH'(INIT_VALUE);
            end else if (state == UPDATE) begin
                action_value_table[chosen] <= updated;
            end
        end
    end

endmodule

// File: tb/tb_epsilon_bandit.sv
// Bench for epsilon_bandit: a greedy agent (index 0) and an always-exploring
// agent with full learning rate (index 1) run against one timing/value model.
module tb_epsilon_bandit;

    localparam int A = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       action_valid [2];
    logic [3:0] action_data  [2];
    logic       action_ready [2];
    logic       reward_valid [2];
    logic [7:0] reward_data  [2];
    logic       reward_ready [2];
    logic       explored     [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    epsilon_bandit #(
        .ACTIONS(16), .VALUE_WIDTH(8), .REWARD_WIDTH(8), .INIT_VALUE(5),
        .RATE_SHIFT(2), .EPSILON(0), .SEED(16'hACE1)
    ) dut (
        .clock(clock), .reset(reset),
        .action_valid(action_valid[0]), .action_data(action_data[0]),
        .action_ready(action_ready[0]), .reward_valid(reward_valid[0]),
        .reward_data(reward_data[0]), .reward_ready(reward_ready[0]),
        .explored(explored[0])
    );

    epsilon_bandit #(
        .ACTIONS(16), .VALUE_WIDTH(8), .REWARD_WIDTH(8), .INIT_VALUE(5),
        .RATE_SHIFT(0), .EPSILON(256), .SEED(16'hACE1)
    ) dut2 (
        .clock(clock), .reset(reset),
        .action_valid(action_valid[1]), .action_data(action_data[1]),
        .action_ready(action_ready[1]), .reward_valid(reward_valid[1]),
        .reward_data(reward_data[1]), .reward_ready(reward_ready[1]),
        .explored(explored[1])
    );

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic signed [31:0] tbl(input int i, input int j);
        if (i == 0) return dut.action_value_table[j];
        return dut2.action_value_table[j];
    endfunction

    // ---------------- reference model ----------------
    int         mq      [2][A];
    logic       m_av    [2];
    logic       m_rr    [2];
    logic       m_ex    [2];
    logic       lat_ex  [2];
    int         m_ad    [2];
    int         m_act   [2];
    int         m_wait  [2];
    int         lat_rand[2];
    logic [15:0] m_lfsr [2];
    int         m_resets = 0;
    bit         started  = 0;

    function automatic int eps_of(input int i);
        return (i == 0) ? 0 : 256;
    endfunction

    function automatic int shift_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int ref_update(input int qv, input int r, input int sh);
        int d;
        int p;
        d = r - qv;
        p = 1 << sh;
        if (d >= 0) return qv + d / p;
        return qv - (-d + p - 1) / p;
    endfunction

    function automatic int argmax_of(input int i);
        int best;
        best = 0;
        for (int j = 1; j < A; j++)
            if (mq[i][j] > mq[i][best]) best = j;
        return best;
    endfunction

    // m_wait counts edges until the next offer; the random draw is taken
    // on the edge that starts the selection phase
    always @(posedge clock) begin
        started = 1;
        if (!reset) m_resets++;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_av[i]   = 0;
                m_rr[i]   = 0;
                m_ex[i]   = 0;
                m_ad[i]   = 0;
                m_wait[i] = 2 * A;
                m_lfsr[i] = 16'hACE1;
                for (int j = 0; j < A; j++) mq[i][j] = 5;
            end else begin
                if (m_wait[i] == A + 1) begin
                    lat_ex[i]   = int'(m_lfsr[i][15:8]) < eps_of(i);
                    lat_rand[i] = int'(m_lfsr[i]) % A;
                end
                if (m_wait[i] > 0) begin
                    m_wait[i]--;
                    if (m_wait[i] == 0) begin
                        m_av[i] = 1;
                        m_ex[i] = lat_ex[i];
                        m_ad[i] = lat_ex[i] ? lat_rand[i] : argmax_of(i);
                    end
                end else if (m_av[i] && action_ready[i]) begin
                    m_av[i]  = 0;
                    m_rr[i]  = 1;
                    m_act[i] = m_ad[i];
                end else if (m_rr[i] && reward_valid[i]) begin
                    m_rr[i] = 0;
                    mq[i][m_act[i]] = ref_update(mq[i][m_act[i]], int'($signed(reward_data[i])), shift_of(i));
                    m_wait[i] = A + 1;
                end
                m_lfsr[i] = m_lfsr[i][0] ? ((m_lfsr[i] >> 1) ^ 16'hB400) : (m_lfsr[i] >> 1);
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("action_valid%0d", i), action_valid[i], m_av[i]);
                check($sformatf("reward_ready%0d", i), reward_ready[i], m_rr[i]);
                if (m_av[i]) begin
                    check($sformatf("action_data%0d", i), action_data[i], m_ad[i]);
                    check($sformatf("explored%0d", i), explored[i], m_ex[i]);
                    for (int j = 0; j < A; j++)
                        check($sformatf("table%0d[%0d]", i, j), tbl(i, j), mq[i][j]);
                end
            end
        end
    end

    // ---------------- always-exploring agent: ready/valid held high ----------------
    int a2;
    int rounds2 = 0;
    int wraps = 0;
    bit pend = 0;
    int pend_a;
    int pend_resets;

    initial begin
        action_ready[1] = 0;
        reward_valid[1] = 0;
        reward_data[1]  = 8'd0;
        @(negedge clock);
        forever begin
            @(negedge clock);
            action_ready[1] = 1;
            reward_valid[1] = 1;
            if (action_valid[1] === 1'b1) begin
                a2 = int'(action_data[1]);
                check("explored_lit", explored[1], 1);
                if (pend && pend_resets == m_resets) begin
                    check("wrap_free_min", tbl(1, pend_a), -128);
                    wraps++;
                end
                pend = 0;
                // alternate +127 / -128 per entry: 127 -> -128 is the extreme step
                if (mq[1][a2] == 127) begin
                    reward_data[1] = 8'h80;
                    pend = 1;
                    pend_a = a2;
                    pend_resets = m_resets;
                end else begin
                    reward_data[1] = 8'd127;
                end
                rounds2++;
            end
        end
    end

    // ---------------- greedy agent: directed scenarios ----------------
    task automatic wait_offer();
        int n;
        n = 0;
        while (action_valid[0] !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (action_valid[0] !== 1'b1) check("offer_timeout", action_valid[0], 1);
    endtask

    task automatic do_round(input logic [7:0] r_match, input int match,
                            input logic [7:0] r_other, output int act);
        wait_offer();
        act = int'(action_data[0]);
        action_ready[0] = 1;
        @(negedge clock);
        action_ready[0] = 0;
        reward_data[0]  = (act == match) ? r_match : r_other;
        reward_valid[0] = 1;
        @(negedge clock);
        reward_valid[0] = 0;
    endtask

    task automatic startup(input int n0);
        int n;
        n = n0;
        while (action_valid[0] !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("startup_cycles", n, 32);
        check("startup_action", action_data[0], 0);
        check("startup_explored", explored[0], 0);
        for (int j = 0; j < A; j++) check($sformatf("startup_q[%0d]", j), tbl(0, j), 5);
    endtask

    initial begin
        int a;
        reset = 0;
        action_ready[0] = 0;
        reward_valid[0] = 0;
        reward_data[0]  = 8'd0;
        repeat (3) @(negedge clock);
        check("reset_valid", action_valid[0], 0);
        check("reset_data", action_data[0], 0);
        check("reset_explored", explored[0], 0);
        check("reset_rready", reward_ready[0], 0);
        check("lfsr_seed", dut2.u_lfsr.state, 16'hACE1);
        reset = 1;
        @(negedge clock);
        check("lfsr_step1", dut2.u_lfsr.state, 16'hE270);
        @(negedge clock);
        check("lfsr_step2", dut2.u_lfsr.state, 16'h7138);
        startup(2);

        // one reward of 3 on entry 0: 5 + floor(-2/4) = 4, greedy moves to 1
        do_round(8'd3, 0, 8'd0, a);
        check("t2_first_action", a, 0);
        wait_offer();
        check("t2_q0", tbl(0, 0), 4);
        check("t2_next_action", action_data[0], 1);

        for (int k = 0; k < 100; k++) begin
            do_round(8'd3, 4, 8'd0, a);
            if (k >= 90) check("t3_late_action", a, 4);
        end
        wait_offer();
        check("t3_q4", tbl(0, 4), 3);
        check("t3_q1", tbl(0, 1), 2);

        // stalled consumer with a stray reward: nothing may move
        reward_valid[0] = 1;
        reward_data[0]  = 8'd77;
        repeat (20) begin
            @(negedge clock);
            check("t4_data_stable", action_data[0], 4);
            check("t4_valid_held", action_valid[0], 1);
            check("t4_rready_low", reward_ready[0], 0);
        end
        reward_valid[0] = 0;
        check("t4_q4_kept", tbl(0, 4), 3);
        do_round(8'd3, 4, 8'd0, a);
        check("t4_action", a, 4);

        // reset while waiting for the reward
        wait_offer();
        action_ready[0] = 1;
        @(negedge clock);
        action_ready[0] = 0;
        check("t6_rready_before", reward_ready[0], 1);
        reset = 0;
        @(negedge clock);
        check("t6_rready_reset", reward_ready[0], 0);
        check("t6_valid_reset", action_valid[0], 0);
        reset = 1;
        startup(0);

        repeat (5) @(negedge clock);
        check("eps_rounds_enough", int'(rounds2 >= 50), 1);
        check("wrap_case_seen", int'(wraps > 0), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/epsilon_bandit.md
# epsilon_bandit

Parametrised epsilon-greedy multi-armed bandit agent, the next generation of the `bandit` core. It keeps a signed action-value table and offers one action per round on a valid/ready action stream. It then waits for the matching reward on a valid/ready reward stream and updates the chosen entry with a shift-based learning rate. New over `bandit`:
- configurable table depth and widths;
- hardware table initialisation to an optimistic value;
- LFSR-driven random exploration.

## Interface
- `ACTIONS`, 256: table depth; power of two, 2..256.
- `ACTION_WIDTH`, `$clog2(ACTIONS)`: action index width.
- `VALUE_WIDTH`, 8: signed table entry width.
- `REWARD_WIDTH`, 8: signed reward width; must be ≤ `VALUE_WIDTH`.
- `INIT_VALUE`, 5: signed value written to every entry after reset.
- `RATE_SHIFT`, 2: learning rate 2^-RATE_SHIFT; range 0..VALUE_WIDTH.
- `EPSILON`, 26: explore probability EPSILON/256; 9-bit, 0 = never explore, 256 = always explore.
- `SEED`, 16'hACE1: LFSR seed; nonzero.

Ports:
- `clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `action_valid`  out  1  action offered.
- `action_data`  out  ACTION_WIDTH  chosen action index.
- `action_ready`  in  1  consumer accepts action.
- `reward_valid`  in  1  reward offered.
- `reward_data`  in  REWARD_WIDTH  signed reward for last accepted action.
- `reward_ready`  out  1  agent accepts reward.
- `explored`  out  1  qualifies `action_data`: 1 = random pick, 0 = greedy.

## Operation
- FSM states: INIT → SELECT → ACTION → REWARD → UPDATE → SELECT.
- INIT:
  - an index counter writes `INIT_VALUE` to entries 0..ACTIONS-1, one per cycle;
  - lasts exactly ACTIONS cycles, then goes to SELECT.
- SELECT:
  - on entry, the current LFSR value is latched; `explore = lfsr[15:8] < EPSILON`, random index = `lfsr[ACTION_WIDTH-1:0]`;
  - a sequential argmax scan visits entries 0..ACTIONS-1, one per cycle;
  - the best entry is replaced only on strictly greater, so ties resolve to the lowest index;
  - always ACTIONS cycles, whatever `explore` is; this gives constant latency;
  - on exit, `action_data` = explore ? random index : argmax, and `explored` = explore.
- ACTION:
  - `action_valid` = 1; `action_data`/`explored` held stable;
  - transfer on a posedge with `action_valid && action_ready`; the accepted index is latched; go to REWARD.
- REWARD:
  - `reward_ready` = 1; `reward_valid` in any other state is ignored, since ready is low;
  - transfer on a posedge with both high; `reward_data` is latched; go to UPDATE.
- UPDATE, one cycle:
  - `diff = sext(r) - Q[a]`, computed at VALUE_WIDTH+1 bits;
  - `delta = diff >>> RATE_SHIFT`, arithmetic (floor);
  - `Q[a] <= Q[a] + delta`, truncated to VALUE_WIDTH;
  - invariant: the result lies in [min(Q,r), max(Q,r)], so no overflow and no saturation logic;
  - then go to SELECT.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1;
  - loads `SEED` in reset and advances every non-reset cycle.
- Reset (any state, including mid-handshake): FSM → INIT; all outputs are cleared and the table is reinitialised.

## Timing
- Reset values: `action_valid` = 0, `action_data` = 0, `explored` = 0, `reward_ready` = 0.
- First `action_valid` rises 2·ACTIONS cycles after the first posedge with `reset` high.
- Per round, after a reward transfer: 1 UPDATE cycle + ACTIONS SELECT cycles, then `action_valid` rises (latency ACTIONS+1).
- `action_valid` falls the cycle after the action transfer; `reward_ready` rises that same cycle.
- `reward_ready` falls the cycle after the reward transfer.
- Combinational paths: no input-to-output paths; no ready-depends-on-valid combinational dependence.

## Structure
- `bandit_pkg` holds:
  - the state enum `state_t`;
  - the LFSR tap constant;
  - the function `value_update(q, r, shift)`, shared with the bench reference model.
- Sub-module `lfsr16` (parameter SEED; ports `clock`, `reset`, `state[15:0]`).
- The table is a register array named `action_value_table`, so the bench can use hierarchical preload/dump as today.

## Test plan
Parameters for all scenarios: ACTIONS=16, EPSILON=0, INIT_VALUE=5, RATE_SHIFT=2 unless stated.
1. Reset, then count cycles → `action_valid` rises at cycle 32 with `action_data`=0, `explored`=0; all entries read 5.
2. Reward 3 to action 0 → Q[0]=4 (diff −2 ≫ 2 = −1); next action = 1.
3. Rewards: 3 for action 4, 0 elsewhere; 100 rounds → zero-reward entries decay 5→3→2→1→0 and Q[4] settles at 3; final 10 actions are all 4.
4. Hold `action_ready` low 20 cycles and drive `reward_valid`=1 during ACTION → `action_data` stable, `reward_ready` stays 0, table unchanged.
5. EPSILON=256, 50 rounds → every `explored`=1 and each action equals the reference model LFSR sequence's low 4 bits; RATE_SHIFT=0 with reward −128 on Q=127 gives −128 with no wrap.
6. Assert `reset` low for one cycle while in REWARD → `reward_ready` 0 next cycle; table returns to all 5; next action at cycle 32 after release.
